// File: rtl/row_collector.sv
// row_collector: packs every DIM consecutive scalar sums into one matrix row
// and hands completed rows downstream over a ready/valid port. A collect
// buffer plus an output register give double buffering, so row N+1 can be
// gathered while row N waits for the consumer.
module row_collector #(
  parameter int DIM   = 2,
  parameter int W_s   = 33,
  parameter int IDX_W = (DIM > 2) ? $clog2(DIM) : 1
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic [W_s-1:0]       sum,
  input  logic                 sumValid,
  input  logic                 rowReady,
  output logic [DIM*W_s-1:0]   row,
  output logic                 rowValid,
  output logic [IDX_W-1:0]     rowIndex,
  output logic                 matrixDone,
  output logic                 overflow
);

  typedef enum logic {
    COLLECT,
    FULL
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

  state_t               state_q, state_n;
  logic [IDX_W-1:0]     col_q, col_n;
  logic [DIM*W_s-1:0]   collect_q, collect_n;

  logic [DIM*W_s-1:0]   row_n;
  logic                 rowValid_n;
  logic [IDX_W-1:0]     rowIndex_n;
  logic                 matrixDone_n;
  logic                 overflow_n;

  logic                 fire;
  logic                 last_col;

  assign fire     = rowValid && rowReady;
  assign last_col = (col_q == LAST_IDX);

  // Next-state logic: decides where each sum lands, when a row moves into the
  // output register, and when a sum has to be dropped.
  always_comb begin
    state_n      = state_q;
    col_n        = col_q;
    collect_n    = collect_q;
    row_n        = row;
    rowValid_n   = rowValid;
    rowIndex_n   = rowIndex;
    matrixDone_n = fire && (rowIndex == LAST_IDX);
    overflow_n   = overflow;

    // A fire empties the output register unless a new row is loaded below;
    // the row index wraps modulo DIM rather than modulo 2^IDX_W.
    if (fire) begin
      rowValid_n = 1'b0;
      rowIndex_n = (rowIndex == LAST_IDX) ? '0 : rowIndex + IDX_W'(1);
    end

    unique case (state_q)
      COLLECT: begin
        if (sumValid) begin
          collect_n[W_s*int'(col_q) +: W_s] = sum;
          if (last_col) begin
            col_n = '0;
            if (!rowValid || fire) begin
              row_n      = collect_n;
              rowValid_n = 1'b1;
            end else begin
              state_n = FULL;
            end
          end else begin
            col_n = col_q + IDX_W'(1);
          end
        end
      end

      FULL: begin
        if (fire) begin
          row_n      = collect_q;
          rowValid_n = 1'b1;
          state_n    = COLLECT;
          if (sumValid) begin
            collect_n[W_s-1:0] = sum;
            col_n              = IDX_W'(1);
          end
        end else if (sumValid) begin
          overflow_n = 1'b1;
        end
      end

      default: begin
        state_n = COLLECT;
        col_n   = '0;
      end
    endcase
  end

  // Collection-side registers: FSM state, column counter and collect buffer.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= COLLECT;
      col_q     <= '0;
      collect_q <= '0;
    end else begin
      state_q   <= state_n;
      col_q     <= col_n;
      collect_q <= collect_n;
    end
  end

  // Output-side registers: every output is driven straight from a flop.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      row        <= '0;
      rowValid   <= 1'b0;
      rowIndex   <= '0;
      matrixDone <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      row        <= row_n;
      rowValid   <= rowValid_n;
      rowIndex   <= rowIndex_n;
      matrixDone <= matrixDone_n;
      overflow   <= overflow_n;
    end
  end

endmodule

// File: doc/row_collector.md
# row_collector

Downstream consumer of the vector-sum stage. Captures the stream of scalar dot-product results (one `sum` per `readEn` pulse) and packs every DIM consecutive results into one result-matrix row. Completed rows go out on a ready/valid port toward the result writer. Double-buffered: collection of row N+1 continues while row N waits for the consumer.

## Interface
- `DIM`, 2: elements per row and rows per matrix; DIM ≥ 2.
- `W_s`, 33: scalar width, equal to the upstream element width + CLOG2(DIM).
- `IDX_W`, CLOG2(DIM) (minimum 1): width of the row index.

- `Clock`  in  1  single clock, rising edge.
- `Reset_n`  in  1  reset, asynchronous, active-low.
- `sum`  in  W_s  scalar result from the vector-sum stage.
- `sumValid`  in  1  one-cycle strobe; `sum` is valid this cycle (wired to the upstream `readEn`).
- `rowReady`  in  1  downstream can take `row` this cycle.
- `row`  out  DIM*W_s  completed row; element c at `row[W_s*c +: W_s]`.
- `rowValid`  out  1  `row` holds a completed row.
- `rowIndex`  out  IDX_W  matrix row number of the row currently on `row`.
- `matrixDone`  out  1  one-cycle pulse after the last row of a matrix transfers.
- `overflow`  out  1  sticky: a `sum` was dropped.

## Operation
- Storage:
  - Collect buffer: DIM×W_s.
  - Column counter `col`: 0..DIM-1.
  - Output register: `row`/`rowValid`.
  - State: COLLECT or FULL.
- Fire: `rowValid && rowReady`.
- COLLECT, `sumValid`=1:
  - `sum` is written to collect slot `col`; `col` increments.
  - If `col` was DIM-1, the row is complete and `col` returns to 0.
    - Output register free (`rowValid`=0) or firing this cycle: the complete row, with this `sum` in slot DIM-1, loads into the output register and `rowValid`=1 next cycle. State stays COLLECT.
    - Otherwise: state → FULL and the collect buffer holds the complete row.
- FULL:
  - On fire: the collect buffer loads into the output register, `rowValid` stays 1, state → COLLECT.
  - `sumValid` on the same cycle as the fire: the `sum` is accepted into slot 0 and `col`=1.
  - `sumValid` in FULL without a fire: the `sum` is dropped and `overflow` is set. `overflow` stays set until reset.
- Fire with no new row to load: `rowValid` → 0.
- `row` and `rowIndex` stay stable while `rowValid && !rowReady`.
- `rowIndex`:
  - Increments on each fire and wraps from DIM-1 to 0.
  - On the fire where `rowIndex`==DIM-1, `matrixDone`=1 for exactly the next cycle.
- Arithmetic: no arithmetic on data; values pass bit-exact. Counters wrap modulo DIM, not 2^IDX_W.

## Timing
- Reset values (asynchronous, on `Reset_n`=0):
  - Outputs: `row`=0, `rowValid`=0, `rowIndex`=0, `matrixDone`=0, `overflow`=0.
  - Internal: `col`=0, state COLLECT, collect buffer=0.
- Reset mid-row or mid-handshake discards all partial and pending data. There is no resumption.
- Latency: `rowValid` rises 1 cycle after the DIM-th `sumValid`, when the output register is free.
- Throughput: one `sum` per cycle sustained when `rowReady` is held high. Back-to-back rows produce no `rowValid` gap.
- Acceptance: `sumValid` has no backpressure; upstream never stalls. Loss shows only through `overflow`.
- All outputs are registered. `rowReady` has no combinational path to any output.

## Test plan
- Basic row: DIM=2, `rowReady`=1, sums 5 then 7 on consecutive cycles → next cycle `row`={7,5}, `rowValid`=1 for 1 cycle, `rowIndex`=0.
- Full matrix: sums 1,2,3,4 back-to-back with `rowReady`=1:
  - Rows {2,1} at index 0, then {4,3} at index 1.
  - `matrixDone` pulses once, the cycle after the second fire.
  - `rowIndex` returns to 0.
- Backpressure/double buffer: `rowReady`=0, sums 1,2,3,4 → `row`={2,1} held stable, state FULL. Raise `rowReady` for 1 cycle → `row`={4,3} next cycle with `rowValid` still 1.
- Overflow: in FULL with `rowReady`=0, drive sum 9 → `overflow`=1 and stays 1. Later rows contain no 9.
- Simultaneous fire and sum in FULL: the fire and sum 8 land in the same cycle → 8 appears in slot 0 of the following row, and `overflow` stays 0.
- Async reset: assert `Reset_n`=0 mid-row with no clock edge → all outputs 0 immediately. After release, sums 5,7 produce {7,5} at index 0.
